mux_store_n: RTL and testbench
==============================

MUX_STORE_N -- requirements
Module: mux_store_n

Interface
REQ-001 Parameter CHANNELS, default 2, number of independent multiplexer channels.
REQ-002 Parameter SEL_W, default 2, select width; INPUTS = 2**SEL_W inputs per channel.
REQ-003 Parameter WIDTH, default 1, bits per input and per output lane.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 rst_n  input  1  reset; one clock, reset synchronous and active-low.
REQ-006 sel  input  SEL_W  external input select, used in SELECT and LOAD modes.
REQ-007 mode  input  2  operating mode: 00 SELECT, 01 SCAN, 10 HOLD, 11 LOAD.
REQ-008 en_n  input  CHANNELS  per-channel enable, active low.
REQ-009 d  input  CHANNELS*INPUTS*WIDTH  data; channel c input i occupies bits [(c*INPUTS+i)*WIDTH +: WIDTH].
REQ-010 y  output  CHANNELS*WIDTH  registered outputs; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-011 scan_idx  output  SEL_W  current internal scan counter value.
REQ-012 wrap  output  1  one-cycle pulse marking scan counter wrap-around.

Function
REQ-013 Latency: y SHALL reflect d sampled at the previous rising edge; no combinational path d->y.
REQ-014 SELECT: each enabled channel c SHALL capture input sel of channel c; scan_idx holds.
REQ-015 SCAN: each enabled channel SHALL capture input scan_idx; scan_idx SHALL increment by 1 modulo INPUTS on the same edge.
REQ-016 HOLD: y and scan_idx SHALL hold their values, including disabled channels.
REQ-017 LOAD: scan_idx SHALL load sel; each enabled channel SHALL capture input sel on the same edge.
REQ-018 Disabled channel (en_n[c]=1) in SELECT, SCAN or LOAD SHALL load all-zeros into its y lane; other channels unaffected.
REQ-019 wrap SHALL be 1 for exactly the cycle following a SCAN edge on which scan_idx was INPUTS-1 (counter now 0); 0 otherwise.
REQ-020 wrap SHALL be set by SCAN only; LOAD of 0 and SELECT SHALL not assert wrap.
REQ-021 Mode change SCAN->SELECT/HOLD SHALL freeze scan_idx; return to SCAN SHALL resume from the frozen value.
REQ-022 sel and mode changes SHALL take effect only at the next rising edge; X-free outputs for all legal input values.
REQ-023 SEL_W=1 SHALL work (INPUTS=2, wrap every second SCAN cycle).

Reset
REQ-024 rst_n=0 at a rising edge SHALL force y=0, scan_idx=0, wrap=0, overriding every mode and enable.
REQ-025 Reset asserted mid-scan SHALL abandon the sequence; first SCAN edge after release SHALL capture input 0.
REQ-026 Before the first rising edge with rst_n=0, output values are unspecified; the bench SHALL not check them.

Verification (defaults CHANNELS=2, SEL_W=2, WIDTH=1; d bits [7:4]=ch1 inputs 3..0, [3:0]=ch0 inputs 3..0)
REQ-027 Reset: rst_n=0 one edge with d=8'hFF, mode=01 -> y=2'b00, scan_idx=0, wrap=0.
REQ-028 SELECT sweep: en_n=00, d=8'b0100_0010, sel=1 then 2 -> y=2'b01 after first edge, 2'b10 after second.
REQ-029 SCAN: d=8'b1000_0001, mode=01 from scan_idx=0 for 5 edges -> y sequence 01,00,00,10,01; scan_idx 1,2,3,0,1; wrap=1 only after 4th edge.
REQ-030 Enable/HOLD: y=2'b11 held, mode=10 with en_n=11 -> y stays 11; then mode=00 with en_n=01 -> ch0 lane 0, ch1 captures.
REQ-031 LOAD then SCAN: sel=3, mode=11, d=8'b1000_1000 -> y=11, scan_idx=3; next SCAN edge -> y=00, scan_idx=0, wrap=1 next cycle.
REQ-032 Reset mid-scan: scan_idx=2, rst_n=0 one edge, then SCAN with d=8'b0001_0001 -> y=11, scan_idx=1, wrap=0.

Source files
------------

// File: rtl/mux_store_n.sv
// mux_store_n: CHANNELS independent registered INPUTS:1 multiplexers sharing one
// select source. The select comes either from the external sel input or from an
// internal scan counter that steps through all inputs and flags its wrap-around.
//
// Ports
//   clk       single clock, all state updates on its rising edge
//   rst_n     synchronous active-low reset: y, scan_idx and wrap go to zero
//   sel       external select (SELECT and LOAD modes), also the LOAD value
//   mode      00 SELECT, 01 SCAN, 10 HOLD, 11 LOAD
//   en_n      per-channel enable, active low; a disabled channel loads zeros
//   d         data, channel c input i at [(c*INPUTS+i)*WIDTH +: WIDTH]
//   y         registered outputs, channel c at [c*WIDTH +: WIDTH]
//   scan_idx  current scan counter value
//   wrap      one-cycle pulse after a SCAN edge that took the counter from INPUTS-1 to 0
module mux_store_n #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned WIDTH    = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [SEL_W-1:0]                   sel,
  input  logic [1:0]                         mode,
  input  logic [CHANNELS-1:0]                en_n,
  input  logic [CHANNELS*(2**SEL_W)*WIDTH-1:0] d,
  output logic [CHANNELS*WIDTH-1:0]          y,
  output logic [SEL_W-1:0]                   scan_idx,
  output logic                               wrap
);

  localparam int unsigned INPUTS = 2 ** SEL_W;

  typedef enum logic [1:0] {
    ModeSelect = 2'b00,
    ModeScan   = 2'b01,
    ModeHold   = 2'b10,
    ModeLoad   = 2'b11
  } mode_e;

  mode_e                      mode_s;
  logic [SEL_W-1:0]           pick;
  logic [CHANNELS*WIDTH-1:0]  y_d, y_q;
  logic [SEL_W-1:0]           scan_idx_d, scan_idx_q;
  logic                       wrap_d, wrap_q;

  assign mode_s = mode_e'(mode);

  // SCAN reads through the counter; every other capturing mode uses sel.
  always_comb begin
    pick = sel;
    if (mode_s == ModeScan) begin
      pick = scan_idx_q;
    end
  end

  // Output lanes.
  always_comb begin
    y_d = y_q;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (mode_s != ModeHold) begin
        if (en_n[c]) begin
          y_d[c*WIDTH +: WIDTH] = '0;
        end else begin
          y_d[c*WIDTH +: WIDTH] = d[(c*INPUTS + 32'(pick))*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Scan counter and wrap flag. The counter is exactly SEL_W bits wide, so the
  // increment wraps modulo INPUTS on its own.
  always_comb begin
    scan_idx_d = scan_idx_q;
    wrap_d     = 1'b0;
    unique case (mode_s)
      ModeScan: begin
        scan_idx_d = scan_idx_q + 1'b1;
        wrap_d     = (scan_idx_q == SEL_W'(INPUTS - 1));
      end
      ModeLoad: begin
        scan_idx_d = sel;
      end
      ModeSelect, ModeHold: begin
        scan_idx_d = scan_idx_q;
      end
      default: begin
        scan_idx_d = scan_idx_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q        <= '0;
      scan_idx_q <= '0;
      wrap_q     <= 1'b0;
    end else begin
      y_q        <= y_d;
      scan_idx_q <= scan_idx_d;
      wrap_q     <= wrap_d;
    end
  end

  assign y        = y_q;
  assign scan_idx = scan_idx_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_mux_store_n.sv
module tb_mux_store_n;

  localparam int unsigned CHANNELS = 2;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned WIDTH    = 1;
  localparam int unsigned INPUTS   = 2 ** SEL_W;
  localparam int unsigned DW       = CHANNELS * INPUTS * WIDTH;
  localparam int unsigned YW       = CHANNELS * WIDTH;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [SEL_W-1:0]    sel = '0;
  logic [1:0]          mode = 2'b00;
  logic [CHANNELS-1:0] en_n = '0;
  logic [DW-1:0]       d = '0;
  logic [YW-1:0]       y;
  logic [SEL_W-1:0]    scan_idx;
  logic                wrap;

  int total = 0;
  int bad = 0;

  mux_store_n #(
    .CHANNELS(CHANNELS),
    .SEL_W   (SEL_W),
    .WIDTH   (WIDTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sel     (sel),
    .mode    (mode),
    .en_n    (en_n),
    .d       (d),
    .y       (y),
    .scan_idx(scan_idx),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  // Reference model: per-channel output values, counter as a plain integer.
  int  m_y [CHANNELS];
  int  m_idx = 0;
  bit  m_wrap = 1'b0;
  bit  m_valid = 1'b0;

  function automatic int input_val(int c, int i);
    int v = 0;
    for (int b = 0; b < int'(WIDTH); b++) begin
      if (d[(c * int'(INPUTS) + i) * int'(WIDTH) + b]) v += (1 << b);
    end
    return v;
  endfunction

  always @(posedge clk) begin
    int k;
    if (!rst_n) begin
      for (int c = 0; c < int'(CHANNELS); c++) m_y[c] = 0;
      m_idx   = 0;
      m_wrap  = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      k = (mode == 2'b01) ? m_idx : int'(sel);
      if (mode != 2'b10) begin
        for (int c = 0; c < int'(CHANNELS); c++) begin
          m_y[c] = en_n[c] ? 0 : input_val(c, k);
        end
      end
      m_wrap = (mode == 2'b01) && (m_idx == int'(INPUTS) - 1);
      if (mode == 2'b01) m_idx = (m_idx + 1) % int'(INPUTS);
      else if (mode == 2'b11) m_idx = int'(sel);
    end
  end

  // Model-vs-DUT compare on every falling edge once reset has been seen.
  always @(negedge clk) begin
    logic [YW-1:0] exp_y;
    if (m_valid) begin
      for (int c = 0; c < int'(CHANNELS); c++) exp_y[c*WIDTH +: WIDTH] = WIDTH'(m_y[c]);
      total++;
      if (y !== exp_y) begin
        bad++;
        $display("FAIL model_y t=%0t got=%b want=%b", $time, y, exp_y);
      end
      total++;
      if (scan_idx !== SEL_W'(m_idx)) begin
        bad++;
        $display("FAIL model_idx t=%0t got=%0d want=%0d", $time, scan_idx, m_idx);
      end
      total++;
      if (wrap !== m_wrap) begin
        bad++;
        $display("FAIL model_wrap t=%0t got=%b want=%b", $time, wrap, m_wrap);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] m, input logic [SEL_W-1:0] s,
                      input logic [CHANNELS-1:0] e, input logic [DW-1:0] dv);
    rst_n = r;
    mode  = m;
    sel   = s;
    en_n  = e;
    d     = dv;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input int wy, input int wi, input int ww);
    check({name, "_y"}, int'(y), wy);
    check({name, "_idx"}, int'(scan_idx), wi);
    check({name, "_wrap"}, int'(wrap), ww);
  endtask

  int scan_y   [5] = '{1, 0, 0, 2, 1};
  int scan_i   [5] = '{1, 2, 3, 0, 1};
  int scan_w   [5] = '{0, 0, 0, 1, 0};

  initial begin
    @(negedge clk);

    // Reset overrides SCAN and all-ones data.
    step(1'b0, 2'b01, 2'd0, 2'b00, 8'hFF);
    check_all("reset", 0, 0, 0);

    // SELECT sweep.
    step(1'b1, 2'b00, 2'd1, 2'b00, 8'b0100_0010);
    check_all("sel1", 1, 0, 0);
    step(1'b1, 2'b00, 2'd2, 2'b00, 8'b0100_0010);
    check_all("sel2", 2, 0, 0);

    // SCAN over five edges from counter 0.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'b01, 2'd0, 2'b00, 8'b1000_0001);
      check_all($sformatf("scan%0d", i), scan_y[i], scan_i[i], scan_w[i]);
    end

    // HOLD keeps lanes even with both channels disabled; then a disabled ch0.
    step(1'b1, 2'b00, 2'd0, 2'b00, 8'hFF);
    check_all("all_ones", 3, 1, 0);
    step(1'b1, 2'b10, 2'd2, 2'b11, 8'h00);
    check_all("hold", 3, 1, 0);
    step(1'b1, 2'b00, 2'd0, 2'b01, 8'b0001_0001);
    check_all("en_ch0_off", 2, 1, 0);

    // LOAD then SCAN; data input 3 cleared before the SCAN edge.
    step(1'b1, 2'b11, 2'd3, 2'b00, 8'b1000_1000);
    check_all("load3", 3, 3, 0);
    step(1'b1, 2'b01, 2'd0, 2'b00, 8'b0111_0111);
    check_all("load_scan", 0, 0, 1);
    step(1'b1, 2'b10, 2'd0, 2'b00, 8'h00);
    check_all("wrap_drop", 0, 0, 0);

    // LOAD of 0 and SELECT never raise wrap.
    step(1'b1, 2'b11, 2'd0, 2'b00, 8'b0000_0001);
    check_all("load0", 1, 0, 0);
    step(1'b1, 2'b00, 2'd3, 2'b10, 8'b0000_1000);
    check_all("sel_ch1_off", 1, 0, 0);

    // Reset in the middle of a scan.
    step(1'b1, 2'b11, 2'd1, 2'b00, 8'h00);
    step(1'b1, 2'b01, 2'd0, 2'b00, 8'h00);
    check_all("pre_rst", 0, 2, 0);
    step(1'b0, 2'b01, 2'd3, 2'b00, 8'hFF);
    check_all("mid_rst", 0, 0, 0);
    step(1'b1, 2'b01, 2'd3, 2'b00, 8'b0001_0001);
    check_all("post_rst", 3, 1, 0);

    // Freeze and resume the counter across a SELECT.
    step(1'b1, 2'b00, 2'd2, 2'b00, 8'b0100_0100);
    check_all("freeze", 3, 1, 0);
    step(1'b1, 2'b01, 2'd0, 2'b00, 8'b0100_0100);
    check_all("resume", 0, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
